machine_csr_unit: RTL
=====================

Name: machine_csr_unit

Overview:
- Machine-mode CSR and trap-state block sitting directly downstream of the machine trap controller.
- Consumes the controller's interrupt-enable, exception-enable, mret and cause outputs; updates mstatus, mepc and mcause.
- Supplies the trap target PC and return PC to the PC mux.
- Feeds the enable/pending bits (mstatus.MIE, mie.MEIE/MTIE, mip.MEIP/MTIP) back to the controller; serves CSR instruction reads and writes from EX.

Parameters:
P_MTVEC_RESET, 32'h0000_0100, reset value of mtvec (mode bits [1:0] must be 0 or 1).
P_VECTORED_EN, 1, 1 = mtvec mode 1 (vectored) accepted; 0 = mode field hardwired to 0.

Ports:
i_clk  in  1  clock
i_rst  in  1  synchronous active-high reset
i_intr_en  in  1  take interrupt this cycle
i_excep_en  in  1  take exception this cycle
i_mret  in  1  mret commit (controller mret_status)
i_intr_cause  in  4  interrupt code (11 ext, 7 timer)
i_exc_cause  in  4  exception code (2 = illegal insn)
i_epc  in  32  PC to save on trap entry
i_meip_raw  in  1  external interrupt line (level)
i_mtip_raw  in  1  timer interrupt line (level)
i_csr_re  in  1  CSR read access
i_csr_we  in  1  CSR write access
i_csr_op  in  2  01 RW, 10 RS (set), 11 RC (clear), 00 no write
i_csr_addr  in  12  CSR address
i_csr_wdata  in  32  rs1/uimm operand
o_csr_rdata  out  32  current CSR value (combinational)
o_csr_illegal  out  1  access to an unimplemented CSR or write to a read-only CSR
o_mie  out  1  mstatus.MIE
o_meie  out  1  mie.MEIE
o_mtie  out  1  mie.MTIE
o_meip  out  1  mip.MEIP (registered)
o_mtip  out  1  mip.MTIP (registered)
o_trap_pc  out  32  trap target PC
o_epc  out  32  mepc, for mret

Behaviour:
- Clocking and reset: one clock i_clk; reset is synchronous, active-high i_rst.
- Reset values:
  - mstatus: MIE = 0, MPIE = 0.
  - mie, mscratch, mepc, mcause, mip = 0.
  - mtvec = P_MTVEC_RESET.
  - All outputs follow, so o_trap_pc = P_MTVEC_RESET & ~3 and o_csr_illegal = 0 when idle.
- Implemented CSRs:
  - mstatus 0x300: bit3 MIE, bit7 MPIE, bits[12:11] MPP read 2'b11; all other bits read 0, writes to them are ignored.
  - mie 0x304: bit7 MTIE, bit11 MEIE; others read 0.
  - mtvec 0x305: [31:2] BASE, [1:0] MODE. A MODE write of 2 or 3 retains the old mode. With P_VECTORED_EN = 0, MODE reads 0.
  - mscratch 0x340: full 32 bits.
  - mepc 0x341: [1:0] always read 0.
  - mcause 0x342: bit31 = interrupt, [3:0] = code, others 0.
  - mip 0x344: bit11 MEIP, bit7 MTIP; read-only.
- CSR write value:
  - RW: new = wdata. RS: new = old | wdata. RC: new = old & ~wdata.
  - Applied on the next rising edge when i_csr_we = 1 and i_csr_op != 00.
  - Write masks per CSR are applied afterwards.
- Illegal accesses: o_csr_illegal = (i_csr_re | i_csr_we) & (address unimplemented | (i_csr_we & address is mip or address[11:10] == 2'b11)). No state changes on an illegal access. o_csr_rdata = 0 for unimplemented addresses.
- mip: each of MEIP and MTIP is sampled through one flop from its raw line. Latency is 1 cycle from raw line to o_meip/o_mtip.
- Trap entry (i_intr_en | i_excep_en), at the next edge:
  - mepc <= i_epc & ~3.
  - MPIE <= MIE; MIE <= 0.
  - mcause <= i_intr_en ? {1, 27'b0, i_intr_cause} : {0, 27'b0, i_exc_cause}.
  - If both enables are high, the interrupt wins.
- mret: MIE <= MPIE; MPIE <= 1. mepc and mcause are unchanged.
- Same-cycle priority: trap entry > mret > CSR write.
  - A lower-priority update to the same register in that cycle is dropped.
  - A CSR write to a register not touched by the winning event still commits (e.g. mscratch write during a trap).
- o_trap_pc (combinational from current mtvec and the incoming event):
  - MODE = 1 and i_intr_en: BASE + 4*i_intr_cause.
  - Otherwise: BASE. BASE means mtvec & ~3.
  - Wraps modulo 2^32.
- o_epc = mepc (registered value). A write to mepc becomes visible on o_epc the cycle after the edge.
- Reset asserted mid-operation overrides any pending trap, mret or write in that cycle.

Test Plan:
1. Reset, then read 0x300/0x305/0x344 -> rdata 32'h0000_1800, 32'h0000_0100, 0; o_csr_illegal = 0.
2. RS 0x300 with 8, RW 0x304 with 32'h880 -> o_mie = 1, o_meie = 1, o_mtie = 1. Pulse i_intr_en with cause 11, i_epc = 32'h0000_2046 -> mepc 32'h0000_2044, mcause 32'h8000_000B, o_mie = 0, mstatus reads 32'h0000_1880.
3. mtvec RW 32'h0000_0201 (vectored), timer interrupt cause 7 -> o_trap_pc = 32'h0000_021C. Exception cause 2 -> o_trap_pc 32'h0000_0200, mcause 32'h0000_0002.
4. After step 2, pulse i_mret -> o_mie = 1, MPIE = 1, o_epc = 32'h0000_2044. Same cycle as mret, RC 0x300 with 8 -> MIE ends at 1 (write dropped).
5. Read 0x7C0, then write 0x344 -> o_csr_illegal = 1 for each; mip unchanged. Raise i_meip_raw -> o_meip = 1 exactly one cycle later.
6. i_intr_en and i_excep_en both high with RW mcause 32'h5 in the same cycle -> mcause = interrupt value, write discarded. Assert i_rst the following cycle -> all registers at reset values.

Source files
------------

// File: rtl/machine_csr_unit.sv
// machine_csr_unit
//   Machine-mode CSR file and trap state. It sits after the machine trap
//   controller and takes its trap-entry and mret strobes to update mstatus,
//   mepc and mcause. It gives the PC mux the trap target and the return PC.
//   It feeds the enable and pending bits back to the controller. It also
//   serves CSR read/write accesses from EX.
// Ports
//   i_clk, i_rst            clock, synchronous active-high reset
//   i_intr_en, i_excep_en   take interrupt / exception at the next edge
//   i_mret                  mret commit
//   i_intr_cause, i_exc_cause, i_epc   trap cause codes and PC to save
//   i_meip_raw, i_mtip_raw  level interrupt lines, registered into mip
//   i_csr_*                 CSR access from EX (re, we, op, addr, wdata)
//   o_csr_rdata             combinational read value of i_csr_addr
//   o_csr_illegal           unimplemented CSR, or write to a read-only CSR
//   o_mie/o_meie/o_mtie     enable bits back to the controller
//   o_meip/o_mtip           registered pending bits
//   o_trap_pc, o_epc        trap target PC and mepc
module machine_csr_unit #(
   parameter logic [31:0] P_MTVEC_RESET = 32'h0000_0100,
   parameter bit          P_VECTORED_EN = 1'b1
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_intr_en,
   input  logic        i_excep_en,
   input  logic        i_mret,
   input  logic [3:0]  i_intr_cause,
   input  logic [3:0]  i_exc_cause,
   input  logic [31:0] i_epc,
   input  logic        i_meip_raw,
   input  logic        i_mtip_raw,
   input  logic        i_csr_re,
   input  logic        i_csr_we,
   input  logic [1:0]  i_csr_op,
   input  logic [11:0] i_csr_addr,
   input  logic [31:0] i_csr_wdata,
   output logic [31:0] o_csr_rdata,
   output logic        o_csr_illegal,
   output logic        o_mie,
   output logic        o_meie,
   output logic        o_mtie,
   output logic        o_meip,
   output logic        o_mtip,
   output logic [31:0] o_trap_pc,
   output logic [31:0] o_epc
);

   localparam logic [11:0] A_MSTATUS  = 12'h300;
   localparam logic [11:0] A_MIE      = 12'h304;
   localparam logic [11:0] A_MTVEC    = 12'h305;
   localparam logic [11:0] A_MSCRATCH = 12'h340;
   localparam logic [11:0] A_MEPC     = 12'h341;
   localparam logic [11:0] A_MCAUSE   = 12'h342;
   localparam logic [11:0] A_MIP      = 12'h344;

   typedef struct packed {
      logic        re;
      logic        we;
      logic [1:0]  op;
      logic [11:0] addr;
      logic [31:0] wdata;
   } csr_req_t;

   csr_req_t req;
   assign req = '{re: i_csr_re, we: i_csr_we, op: i_csr_op,
                  addr: i_csr_addr, wdata: i_csr_wdata};

   // architectural state
   logic        st_mie, st_mpie;
   logic        ie_meie, ie_mtie;
   logic [31:2] tvec_base;
   logic        tvec_mode;      // only modes 0 and 1 are ever held
   logic [31:0] mscratch;
   logic [31:0] mepc;           // bits [1:0] kept at zero
   logic        cause_int;
   logic [3:0]  cause_code;
   logic        ip_meip, ip_mtip;

   logic        impl;
   logic [31:0] cur;
   logic [31:0] wval;
   logic        wr_ok;
   logic        trap;

   assign trap = i_intr_en | i_excep_en;

   // read mux; also gives the old value for RS/RC
   always_comb begin
      impl = 1'b1;
      cur  = '0;
      case (req.addr)
         A_MSTATUS:  cur = {19'b0, 2'b11, 3'b0, st_mpie, 3'b0, st_mie, 3'b0};
         A_MIE:      cur = {20'b0, ie_meie, 3'b0, ie_mtie, 7'b0};
         A_MTVEC:    cur = {tvec_base, 1'b0, tvec_mode};
         A_MSCRATCH: cur = mscratch;
         A_MEPC:     cur = mepc;
         A_MCAUSE:   cur = {cause_int, 27'b0, cause_code};
         A_MIP:      cur = {20'b0, ip_meip, 3'b0, ip_mtip, 7'b0};
         default:    impl = 1'b0;
      endcase
   end

   assign o_csr_rdata   = cur;
   assign o_csr_illegal = (req.re | req.we) &
                          (~impl | (req.we & ((req.addr == A_MIP) | (req.addr[11:10] == 2'b11))));
   assign wr_ok         = req.we & (req.op != 2'b00) & ~o_csr_illegal;

   always_comb begin
      case (req.op)
         2'b10:   wval = cur | req.wdata;
         2'b11:   wval = cur & ~req.wdata;
         default: wval = req.wdata;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         st_mie     <= 1'b0;
         st_mpie    <= 1'b0;
         ie_meie    <= 1'b0;
         ie_mtie    <= 1'b0;
         tvec_base  <= P_MTVEC_RESET[31:2];
         tvec_mode  <= P_MTVEC_RESET[0] & P_VECTORED_EN;
         mscratch   <= '0;
         mepc       <= '0;
         cause_int  <= 1'b0;
         cause_code <= '0;
         ip_meip    <= 1'b0;
         ip_mtip    <= 1'b0;
      end else begin
         ip_meip <= i_meip_raw;
         ip_mtip <= i_mtip_raw;

         if (trap) begin
            mepc       <= i_epc & ~32'h3;
            st_mpie    <= st_mie;
            st_mie     <= 1'b0;
            cause_int  <= i_intr_en;
            cause_code <= i_intr_en ? i_intr_cause : i_exc_cause;
         end else if (i_mret) begin
            st_mie  <= st_mpie;
            st_mpie <= 1'b1;
         end

         // CSR writes lose only against an event touching the same register
         if (wr_ok) begin
            case (req.addr)
               A_MSTATUS: if (!trap && !i_mret) begin
                  st_mie  <= wval[3];
                  st_mpie <= wval[7];
               end
               A_MIE: begin
                  ie_meie <= wval[11];
                  ie_mtie <= wval[7];
               end
               A_MTVEC: begin
                  tvec_base <= wval[31:2];
                  // reserved modes 2/3 leave the old mode in place
                  if (P_VECTORED_EN && !wval[1]) tvec_mode <= wval[0];
               end
               A_MSCRATCH: mscratch <= wval;
               A_MEPC:     if (!trap) mepc <= wval & ~32'h3;
               A_MCAUSE:   if (!trap) begin
                  cause_int  <= wval[31];
                  cause_code <= wval[3:0];
               end
               default: ;
            endcase
         end
      end
   end

   assign o_mie  = st_mie;
   assign o_meie = ie_meie;
   assign o_mtie = ie_mtie;
   assign o_meip = ip_meip;
   assign o_mtip = ip_mtip;
   assign o_epc  = mepc;

   // vectored offset only for interrupts; sum wraps naturally at 32 bits
   assign o_trap_pc = {tvec_base, 2'b00} +
                      ((tvec_mode & i_intr_en) ? {26'b0, i_intr_cause, 2'b00} : 32'h0);

endmodule
